// File: rtl/volt_rx4.sv
// Pin input receiver: Schmitt-trigger thresholding of a 4-bit pin level against vdd,
// followed by a debounce FSM producing a clean level, edge pulses and a sticky interrupt flag.
module volt_rx4 #(
    parameter int HI_NUM = 6,
    parameter int LO_NUM = 2,
    parameter int DEB    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       smp,
    input  logic [3:0] vdd,
    input  logic [3:0] pin,
    input  logic       intedg,
    input  logic       int_clr,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic       int_flag
);

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CONF_H = 2'd1,
        S_HIGH   = 2'd2,
        S_CONF_L = 2'd3
    } state_t;

    localparam logic [6:0] HI_W  = 7'(HI_NUM);
    localparam logic [6:0] LO_W  = 7'(LO_NUM);
    localparam logic [4:0] DEB_W = 5'(DEB);

    logic [6:0] w_prod_hi;
    logic [6:0] w_prod_lo;
    logic [3:0] w_vih;
    logic [3:0] w_vil;

    logic       r_sch;
    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_cnt_done;

    logic       r_level;
    logic       r_rise;
    logic       r_fall;
    logic       r_int_flag;
    logic       w_level_next;
    logic       w_rise_next;
    logic       w_fall_next;
    logic       w_int_set;

    // Thresholds are fractions of vdd in eighths, truncated toward zero.
    assign w_prod_hi = {3'b000, vdd} * HI_W;
    assign w_prod_lo = {3'b000, vdd} * LO_W;
    assign w_vih     = 4'(w_prod_hi >> 3);
    assign w_vil     = 4'(w_prod_lo >> 3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sch <= 1'b0;
        end else if (smp) begin
            if (vdd == 4'd0) begin
                r_sch <= 1'b0;
            end else if (pin >= w_vih) begin
                r_sch <= 1'b1;
            end else if (pin <= w_vil) begin
                r_sch <= 1'b0;
            end
        end
    end

    // State register, including the registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LOW;
            r_cnt      <= 4'd0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_int_flag <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
            if (w_int_set) begin
                r_int_flag <= 1'b1;
            end else if (int_clr) begin
                r_int_flag <= 1'b0;
            end
        end
    end

    assign w_cnt_done = (({1'b0, r_cnt} + 5'd1) == DEB_W);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (smp) begin
            case (r_state)
                S_LOW: begin
                    if (r_sch) begin
                        if (DEB == 1) begin
                            w_state_next = S_HIGH;
                        end else begin
                            w_state_next = S_CONF_H;
                            w_cnt_next   = 4'd1;
                        end
                    end
                end
                S_CONF_H: begin
                    if (!r_sch) begin
                        w_state_next = S_LOW;
                        w_cnt_next   = 4'd0;
                    end else if (w_cnt_done) begin
                        w_state_next = S_HIGH;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_cnt_next   = r_cnt + 4'd1;
                    end
                end
                S_HIGH: begin
                    if (!r_sch) begin
                        if (DEB == 1) begin
                            w_state_next = S_LOW;
                        end else begin
                            w_state_next = S_CONF_L;
                            w_cnt_next   = 4'd1;
                        end
                    end
                end
                default: begin
                    if (r_sch) begin
                        w_state_next = S_HIGH;
                        w_cnt_next   = 4'd0;
                    end else if (w_cnt_done) begin
                        w_state_next = S_LOW;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_cnt_next   = r_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Pulses fire only on a real debounced transition, never on a glitch returning home.
    always_comb begin
        w_level_next = (w_state_next == S_HIGH) || (w_state_next == S_CONF_L);
        w_rise_next  = (w_state_next == S_HIGH) &&
                       ((r_state == S_LOW) || (r_state == S_CONF_H));
        w_fall_next  = (w_state_next == S_LOW) &&
                       ((r_state == S_HIGH) || (r_state == S_CONF_L));
        w_int_set    = (w_rise_next && intedg) || (w_fall_next && !intedg);
    end

    assign level    = r_level;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign int_flag = r_int_flag;

endmodule

// File: tb/tb_volt_rx4.sv
// Bench for volt_rx4: directed scenarios plus random traffic, all outputs compared every
// cycle against a counting model of the Schmitt + debounce behaviour.
module tb_volt_rx4;

    localparam int HI_NUM = 6;
    localparam int LO_NUM = 2;
    localparam int DEB    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       smp = 1'b0;
    logic [3:0] vdd = 4'd0;
    logic [3:0] pin = 4'd0;
    logic       intedg = 1'b1;
    logic       int_clr = 1'b0;
    logic       level, rise, fall, int_flag;

    int n_vec = 0;
    int n_bad = 0;

    // Model: a level plus a run-length of consecutive samples disagreeing with it.
    int m_sch, m_level, m_run, m_rise, m_fall, m_int;

    volt_rx4 #(.HI_NUM(HI_NUM), .LO_NUM(LO_NUM), .DEB(DEB)) dut (
        .clk(clk), .rst(rst), .smp(smp), .vdd(vdd), .pin(pin),
        .intedg(intedg), .int_clr(int_clr),
        .level(level), .rise(rise), .fall(fall), .int_flag(int_flag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int vih, vil;
        if (rst) begin
            m_sch = 0; m_level = 0; m_run = 0; m_rise = 0; m_fall = 0; m_int = 0;
            return;
        end
        m_rise = 0;
        m_fall = 0;
        if (smp) begin
            if (m_sch != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = 1 - m_level;
                    m_run   = 0;
                    if (m_level == 1) m_rise = 1; else m_fall = 1;
                end
            end else begin
                m_run = 0;
            end
            vih = (int'(vdd) * HI_NUM) / 8;
            vil = (int'(vdd) * LO_NUM) / 8;
            if (vdd == 0)            m_sch = 0;
            else if (int'(pin) >= vih) m_sch = 1;
            else if (int'(pin) <= vil) m_sch = 0;
        end
        if ((m_rise == 1 && intedg) || (m_fall == 1 && !intedg)) m_int = 1;
        else if (int_clr) m_int = 0;
    endtask

    task automatic step(input logic r, input logic s, input logic [3:0] v, input logic [3:0] p,
                        input logic ie, input logic ic);
        rst = r; smp = s; vdd = v; pin = p; intedg = ie; int_clr = ic;
        @(posedge clk);
        model_edge();
        #1;
        check_val("level", int'(level), m_level);
        check_val("rise", int'(rise), m_rise);
        check_val("fall", int'(fall), m_fall);
        check_val("int_flag", int'(int_flag), m_int);
        check_val("rise_fall_excl", int'(rise & fall), 0);
        $display("t=%0t rst=%b smp=%b vdd=%0d pin=%0d ie=%b clr=%b -> lvl=%b r=%b f=%b int=%b",
                 $time, r, s, v, p, ie, ic, level, rise, fall, int_flag);
    endtask

    initial begin
        m_sch = 0; m_level = 0; m_run = 0; m_rise = 0; m_fall = 0; m_int = 0;

        // Reset then a clean rising edge: level goes high at edge 3.
        step(1, 1, 12, 0, 1, 0);
        check_val("reset_level", int'(level), 0);
        check_val("reset_int", int'(int_flag), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 12, 12, 1, 0);
            check_val("rise_wait_level", int'(level), 0);
        end
        step(0, 1, 12, 12, 1, 0);
        check_val("rise_edge3_level", int'(level), 1);
        check_val("rise_edge3_pulse", int'(rise), 1);
        check_val("rise_edge3_int", int'(int_flag), 1);
        step(0, 1, 12, 12, 1, 0);
        check_val("rise_pulse_end", int'(rise), 0);

        // Hysteresis band holds the high level; pin=VIL then falls.
        for (int i = 0; i < 10; i++) step(0, 1, 12, 5, 1, 0);
        check_val("hyst_level", int'(level), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 12, 3, 1, 1);
        check_val("hyst_fall_level", int'(level), 0);

        // Glitch rejection: two high samples then low.
        step(0, 1, 12, 12, 1, 0);
        step(0, 1, 12, 12, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 12, 0, 1, 0);
        check_val("glitch_level", int'(level), 0);

        // Sample gating: strobe pattern 1,0,0 during a rising input.
        for (int i = 0; i < 15; i++) step(0, (i % 3) == 0, 12, 12, 1, 0);
        check_val("gated_level", int'(level), 1);

        // Interrupt flag: falling edge with intedg=0, clear racing a new fall, clear alone.
        step(0, 1, 12, 12, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 12, 0, 0, 0);
        check_val("intfall_flag", int'(int_flag), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 12, 12, 0, 0);
        step(0, 1, 12, 0, 0, 0);
        step(0, 1, 12, 0, 0, 0);
        step(0, 1, 12, 0, 0, 0);
        step(0, 1, 12, 0, 0, 1);
        check_val("set_beats_clear", int'(int_flag), 1);
        step(0, 1, 12, 0, 0, 1);
        check_val("clear_alone", int'(int_flag), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 12, 12, 0, 0);
        check_val("rise_no_int", int'(int_flag), 0);

        // Reset while confirming high, then vdd=0 with a high pin never rises.
        for (int i = 0; i < 5; i++) step(0, 1, 12, 0, 1, 0);
        step(0, 1, 12, 12, 1, 0);
        step(0, 1, 12, 12, 1, 0);
        step(0, 1, 12, 12, 1, 0);
        step(1, 1, 12, 12, 1, 0);
        check_val("midreset_level", int'(level), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 15, 1, 0);
        check_val("vdd0_level", int'(level), 0);

        // Random traffic, biased towards rail levels so transitions actually complete.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] v, p;
            logic r, s, ie, ic;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 9) < 8);
            v  = ($urandom_range(0, 19) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            case ($urandom_range(0, 2))
                0: p = 4'd0;
                1: p = 4'd15;
                default: p = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 3) != 0) p = pin;
            ie = ($urandom_range(0, 9) == 0) ? ~intedg : intedg;
            ic = ($urandom_range(0, 7) == 0);
            step(r, s, v, p, ie, ic);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
